// File: rtl/run_ctrl_pkg.sv
// Shared types and default widths for the run-control / performance-count unit.
package run_ctrl_pkg;

    localparam int PC_W_DEF  = 9;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Program-select width; a single program still needs a 1-bit select port.
    function automatic int sel_w(input int num_progs);
        return (num_progs > 1) ? $clog2(num_progs) : 1;
    endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Run-control bundle between the core environment (master) and run_controller (slave).
interface run_ctrl_if
    import run_ctrl_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int NUM_PROGS = 4
) ();

    localparam int SEL_W = sel_w(NUM_PROGS);

    logic                      start;
    logic [SEL_W-1:0]          prog_sel;
    logic [NUM_PROGS*PC_W-1:0] prog_base;
    logic [CNT_W-1:0]          timeout_lim;
    logic                      halt_in;
    logic                      branch;
    logic                      taken;
    logic                      stall;

    logic                      init;
    logic [PC_W-1:0]           start_addr;
    logic                      run;
    logic                      done;
    logic                      timed_out;
    logic                      sat;
    logic [CNT_W-1:0]          instr_count;
    logic [CNT_W-1:0]          cycle_count;
    logic [CNT_W-1:0]          taken_count;
    state_t                    state_dbg;

    modport master (
        output start, prog_sel, prog_base, timeout_lim, halt_in, branch, taken, stall,
        input  init, start_addr, run, done, timed_out, sat,
               instr_count, cycle_count, taken_count, state_dbg
    );

    modport slave (
        input  start, prog_sel, prog_base, timeout_lim, halt_in, branch, taken, stall,
        output init, start_addr, run, done, timed_out, sat,
               instr_count, cycle_count, taken_count, state_dbg
    );

endinterface

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all-ones; ovf pulses when an increment is lost.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         ovf
);

    logic [W-1:0] count_q, count_d;
    logic         full;

    assign full = &count_q;
    assign q    = count_q;
    assign ovf  = inc && !clr && full;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !full) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/run_controller.sv
// Start/halt sequencing for the 9-bit core with a watchdog and saturating
// instruction, cycle and taken-branch counters.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int NUM_PROGS = 4
) (
    input  logic     clk,
    input  logic     reset,
    run_ctrl_if.slave bus
);

    localparam int SEL_W = sel_w(NUM_PROGS);

    // Handshake: start is a level request accepted in any state except LOAD
    // (a request in RUN aborts the run); done is a level that stays high in
    // DONE until the next accepted start, and drops when LOAD is entered.
    state_t          state_q, state_d;
    logic [PC_W-1:0] start_addr_q, start_addr_d;
    logic            timed_out_q, timed_out_d;
    logic            sat_q, sat_d;

    logic            in_run, clr, accept, halt_go, wd_hit;
    logic            ins_inc, tkn_inc;
    logic            ins_ovf, cyc_ovf, tkn_ovf;
    logic [CNT_W-1:0] ins_cnt, cyc_cnt, tkn_cnt;
    logic [PC_W-1:0] entry;

    assign in_run  = (state_q == RUN);
    assign clr     = (state_q == LOAD);
    assign accept  = bus.start && (state_q != LOAD);
    assign halt_go = bus.halt_in && !bus.stall;
    assign wd_hit  = (bus.timeout_lim != '0) && ((cyc_cnt + CNT_W'(1)) == bus.timeout_lim);
    assign ins_inc = in_run && !bus.stall && !bus.halt_in;
    assign tkn_inc = ins_inc && bus.branch && bus.taken;

    // Out-of-range selects match no entry and fall back to entry 0.
    always_comb begin
        entry = bus.prog_base[PC_W-1:0];
        for (int i = 1; i < NUM_PROGS; i++) begin
            if (bus.prog_sel == SEL_W'(i)) begin
                entry = bus.prog_base[i*PC_W +: PC_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        timed_out_d  = timed_out_q;
        sat_d        = sat_q | ins_ovf | cyc_ovf | tkn_ovf;
        case (state_q)
            IDLE: if (bus.start) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN: begin
                if (bus.start) begin
                    state_d = LOAD;
                end else if (halt_go) begin
                    state_d = DONE;
                end else if (wd_hit) begin
                    state_d     = DONE;
                    timed_out_d = 1'b1;
                end
            end
            DONE: if (bus.start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            start_addr_d = entry;
        end
        if (clr) begin
            timed_out_d = 1'b0;
            sat_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            start_addr_q <= '0;
            timed_out_q  <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            timed_out_q  <= timed_out_d;
            sat_q        <= sat_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(ins_inc), .q(ins_cnt), .ovf(ins_ovf)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(in_run), .q(cyc_cnt), .ovf(cyc_ovf)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(tkn_inc), .q(tkn_cnt), .ovf(tkn_ovf)
    );

    assign bus.init        = (state_q == LOAD);
    assign bus.run         = in_run;
    assign bus.done        = (state_q == DONE);
    assign bus.start_addr  = start_addr_q;
    assign bus.timed_out   = timed_out_q;
    assign bus.sat         = sat_q;
    assign bus.instr_count = ins_cnt;
    assign bus.cycle_count = cyc_cnt;
    assign bus.taken_count = tkn_cnt;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench: a 16-bit-counter instance and a 4-bit-counter instance share
// one stimulus stream; expected values are hand-computed per step.
module tb_run_controller
    import run_ctrl_pkg::*;
;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  prog_sel = 2'd0;
    logic [26:0] prog_base;
    logic [15:0] timeout_lim = 16'd0;
    logic        halt_in = 1'b0;
    logic        branch = 1'b0;
    logic        taken = 1'b0;
    logic        stall = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Entries: 0 -> 0x010, 1 -> 0x040, 2 -> 0x123
    assign prog_base = {9'h123, 9'h040, 9'h010};

    always #5 clk = ~clk;

    run_ctrl_if #(.PC_W(9), .CNT_W(16), .NUM_PROGS(3)) bus_a ();
    run_ctrl_if #(.PC_W(9), .CNT_W(4),  .NUM_PROGS(3)) bus_b ();

    assign bus_a.start       = start;
    assign bus_a.prog_sel    = prog_sel;
    assign bus_a.prog_base   = prog_base;
    assign bus_a.timeout_lim = timeout_lim;
    assign bus_a.halt_in     = halt_in;
    assign bus_a.branch      = branch;
    assign bus_a.taken       = taken;
    assign bus_a.stall       = stall;

    assign bus_b.start       = start;
    assign bus_b.prog_sel    = prog_sel;
    assign bus_b.prog_base   = prog_base;
    assign bus_b.timeout_lim = 4'd0;
    assign bus_b.halt_in     = halt_in;
    assign bus_b.branch      = branch;
    assign bus_b.taken       = taken;
    assign bus_b.stall       = stall;

    run_controller #(.PC_W(9), .CNT_W(16), .NUM_PROGS(3)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    run_controller #(.PC_W(9), .CNT_W(4), .NUM_PROGS(3)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start pulse, check the LOAD cycle, then land in the first RUN cycle.
    task automatic launch(input logic [1:0] sel, input logic [8:0] exp_addr, input string tag);
        start    = 1'b1;
        prog_sel = sel;
        halt_in  = 1'b0;
        stall    = 1'b0;
        branch   = 1'b0;
        taken    = 1'b0;
        step();
        check_eq({tag, "_init"}, 32'(bus_a.init), 32'd1);
        check_eq({tag, "_addr"}, 32'(bus_a.start_addr), 32'(exp_addr));
        check_eq({tag, "_load_done"}, 32'(bus_a.done), 32'd0);
        start = 1'b0;
        step();
        check_eq({tag, "_run"}, 32'(bus_a.run), 32'd1);
        check_eq({tag, "_init_low"}, 32'(bus_a.init), 32'd0);
        check_eq({tag, "_clr_cyc"}, 32'(bus_a.cycle_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL tb_watchdog: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] v_stall, v_branch, v_taken, v_halt;
        v_stall  = 8'b0101_0010;
        v_branch = 8'b0011_1001;
        v_taken  = 8'b0001_1001;
        v_halt   = 8'b0100_0000;

        // Reset state
        #2;
        check_eq("rst_state", 32'(bus_a.state_dbg), 32'(IDLE));
        check_eq("rst_addr", 32'(bus_a.start_addr), 32'd0);
        check_eq("rst_run_done", 32'({bus_a.init, bus_a.run, bus_a.done}), 32'd0);
        check_eq("rst_cnt", 32'(bus_a.instr_count | bus_a.cycle_count | bus_a.taken_count), 32'd0);
        step();
        reset = 1'b0;
        step();
        check_eq("idle_hold", 32'(bus_a.state_dbg), 32'(IDLE));

        // Basic run: 10 instructions then halt
        launch(2'd1, 9'h040, "t2");
        repeat (10) step();
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        check_eq("t2_done", 32'(bus_a.done), 32'd1);
        check_eq("t2_run_low", 32'(bus_a.run), 32'd0);
        check_eq("t2_instr", 32'(bus_a.instr_count), 32'd10);
        check_eq("t2_cycle", 32'(bus_a.cycle_count), 32'd11);
        check_eq("t2_tmo", 32'(bus_a.timed_out), 32'd0);
        step();
        check_eq("t2_done_hold", 32'(bus_a.done), 32'd1);

        // Stalls and branches: 8 cycles, halt-while-stalled ignored
        launch(2'd1, 9'h040, "t3");
        for (int i = 0; i < 8; i++) begin
            stall   = v_stall[i];
            branch  = v_branch[i];
            taken   = v_taken[i];
            halt_in = v_halt[i];
            step();
        end
        check_eq("t3_still_run", 32'(bus_a.run), 32'd1);
        stall   = 1'b0;
        branch  = 1'b0;
        taken   = 1'b0;
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        check_eq("t3_done", 32'(bus_a.done), 32'd1);
        check_eq("t3_instr", 32'(bus_a.instr_count), 32'd5);
        check_eq("t3_taken", 32'(bus_a.taken_count), 32'd2);
        check_eq("t3_cycle", 32'(bus_a.cycle_count), 32'd9);

        // Watchdog fires after 20 RUN cycles
        timeout_lim = 16'd20;
        launch(2'd0, 9'h010, "t4");
        repeat (19) step();
        check_eq("t4_run_19", 32'(bus_a.run), 32'd1);
        step();
        check_eq("t4_done", 32'(bus_a.done), 32'd1);
        check_eq("t4_cycle", 32'(bus_a.cycle_count), 32'd20);
        check_eq("t4_tmo", 32'(bus_a.timed_out), 32'd1);
        check_eq("t4_instr", 32'(bus_a.instr_count), 32'd20);

        // Halt on the watchdog cycle wins
        launch(2'd0, 9'h010, "t4b");
        check_eq("t4b_tmo_clr", 32'(bus_a.timed_out), 32'd0);
        repeat (19) step();
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        check_eq("t4b_done", 32'(bus_a.done), 32'd1);
        check_eq("t4b_tmo", 32'(bus_a.timed_out), 32'd0);
        check_eq("t4b_cycle", 32'(bus_a.cycle_count), 32'd20);
        check_eq("t4b_instr", 32'(bus_a.instr_count), 32'd19);

        // Saturation on the 4-bit instance
        timeout_lim = 16'd0;
        launch(2'd1, 9'h040, "t5");
        repeat (20) step();
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        check_eq("t5_b_done", 32'(bus_b.done), 32'd1);
        check_eq("t5_b_instr", 32'(bus_b.instr_count), 32'd15);
        check_eq("t5_b_cycle", 32'(bus_b.cycle_count), 32'd15);
        check_eq("t5_b_sat", 32'(bus_b.sat), 32'd1);
        check_eq("t5_a_instr", 32'(bus_a.instr_count), 32'd20);
        check_eq("t5_a_cycle", 32'(bus_a.cycle_count), 32'd21);
        check_eq("t5_a_sat", 32'(bus_a.sat), 32'd0);

        // Next LOAD clears sat; then restart mid-RUN with out-of-range select
        launch(2'd2, 9'h123, "t6");
        check_eq("t6_b_sat_clr", 32'(bus_b.sat), 32'd0);
        check_eq("t6_b_instr_clr", 32'(bus_b.instr_count), 32'd0);
        repeat (3) step();
        check_eq("t6_cycle_pre", 32'(bus_a.cycle_count), 32'd3);
        start    = 1'b1;
        prog_sel = 2'd3;
        step();
        check_eq("t6_reload_state", 32'(bus_a.state_dbg), 32'(LOAD));
        check_eq("t6_reload_init", 32'(bus_a.init), 32'd1);
        check_eq("t6_reload_addr", 32'(bus_a.start_addr), 32'h010);
        start = 1'b0;
        step();
        check_eq("t6_rerun", 32'(bus_a.run), 32'd1);
        check_eq("t6_cnt_clr", 32'(bus_a.instr_count | bus_a.cycle_count | bus_a.taken_count), 32'd0);
        repeat (2) step();
        check_eq("t6_instr", 32'(bus_a.instr_count), 32'd2);
        check_eq("t6_cycle", 32'(bus_a.cycle_count), 32'd2);

        // Asynchronous reset mid-RUN
        launch(2'd1, 9'h040, "t1");
        repeat (5) step();
        check_eq("t1_cycle_pre", 32'(bus_a.cycle_count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t1_state", 32'(bus_a.state_dbg), 32'(IDLE));
        check_eq("t1_flags", 32'({bus_a.init, bus_a.run, bus_a.done, bus_a.timed_out, bus_a.sat}), 32'd0);
        check_eq("t1_addr", 32'(bus_a.start_addr), 32'd0);
        check_eq("t1_cnt", 32'(bus_a.instr_count | bus_a.cycle_count | bus_a.taken_count), 32'd0);
        check_eq("t1_b_cnt", 32'(bus_b.instr_count | bus_b.cycle_count), 32'd0);
        step();
        check_eq("t1_no_done", 32'(bus_a.done), 32'd0);
        reset = 1'b0;
        step();
        check_eq("t1_idle_after", 32'(bus_a.state_dbg), 32'(IDLE));
        check_eq("t1_no_done2", 32'(bus_a.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Parametrised run-control and performance-count unit for the 9-bit-instruction core.
- Generalises the original start/halt/instruction-count logic in three ways:
  - multi-program start-address selection;
  - an explicit run/done handshake FSM with a watchdog timeout;
  - saturating instruction, cycle and taken-branch counters of configurable width.
- Sits beside fetch_unit and decoder:
  - drives the start address and the PC-load pulse into fetch;
  - observes halt, branch, taken and stall from the datapath.

Parameters:
- PC_W, 9, width of instruction address (matches instr_width).
- CNT_W, 16, width of each performance counter.
- NUM_PROGS, 4, number of selectable program entry points (>=1).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled every cycle.
- prog_sel  in  $clog2(NUM_PROGS) (min 1)  program index, sampled with start.
- prog_base  in  NUM_PROGS*PC_W  packed entry-point table; entry i is bits [i*PC_W +: PC_W].
- timeout_lim  in  CNT_W  watchdog cycle limit; 0 disables the watchdog.
- halt_in  in  1  decoder halt indication.
- branch  in  1  current instruction is a branch.
- taken  in  1  branch resolved taken.
- stall  in  1  fetch did not advance this cycle.
- init  out  1  one-cycle PC-load pulse to fetch_unit.
- start_addr  out  PC_W  latched entry address.
- run  out  1  core enabled.
- done  out  1  run finished, level.
- timed_out  out  1  the last run ended by watchdog.
- sat  out  1  sticky: some counter saturated this run.
- instr_count  out  CNT_W  retired instructions.
- cycle_count  out  CNT_W  cycles spent in RUN.
- taken_count  out  CNT_W  taken branches retired.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE;
  - every output = 0, including start_addr and all counters.
- IDLE: on start=1 go to LOAD; otherwise hold.
- LOAD (exactly 1 cycle):
  - init=1;
  - start_addr <= prog_base entry prog_sel; if prog_sel >= NUM_PROGS, use entry 0;
  - all counters, sat and timed_out cleared to 0;
  - done=0; next state RUN.
- RUN:
  - run=1.
  - Every cycle: cycle_count++.
  - If !stall && !halt_in: instr_count++. The halt instruction itself is not counted.
  - If !stall && branch && taken && !halt_in: taken_count++.
  - If halt_in && !stall: go to DONE. Counter updates in that cycle apply except instr/taken, per the rules above.
  - If timeout_lim != 0 and cycle_count+1 == timeout_lim: set timed_out=1 and go to DONE.
  - If halt and timeout fire in the same cycle: halt wins and timed_out=0.
  - start=1 in RUN: abort and restart. Next state is LOAD, with prog_sel re-sampled.
- DONE:
  - done=1, run=0; counters, sat and timed_out hold for readout.
  - On start=1 go to LOAD, which drops done the next cycle.
- Latencies:
  - start to init is 1 cycle; init to run is 1 cycle.
  - halt_in to done is 1 cycle.
- Counter arithmetic:
  - unsigned CNT_W bits, saturating at all-ones, no wrap;
  - any increment attempted at all-ones sets sat; sat stays set until the next LOAD.
- Reset asserted mid-RUN: immediate return to IDLE with outputs zeroed; no done pulse.
- Outputs are registered except init, run and done, which are decoded from state.

Decomposition:
- Package run_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE), 2-bit encoding;
  - default width constants PC_W_DEF=9 and CNT_W_DEF=16.
- One sub-module, sat_counter #(W), with ports clk, reset, clr, inc, q, ovf (pulse on attempted overflow).
  - Instantiated three times.
  - Each ovf is ORed into sat.

Test Plan:
1. Reset mid-RUN:
   - stimulus: assert reset after 5 RUN cycles;
   - response: same-cycle IDLE; outputs and counters 0; no done.
2. Basic run:
   - stimulus: prog_base entry1=0x040, prog_sel=1, start pulse; 10 non-stalled instructions, then halt_in;
   - response: init for 1 cycle; start_addr=0x040; instr_count=10; cycle_count=11; done=1; timed_out=0.
3. Stalls and branches:
   - stimulus: 8 RUN cycles with stall on 3 of them, and 2 taken branches on non-stall cycles, then halt;
   - response: instr_count=5; taken_count=2; cycle_count=9.
4. Watchdog:
   - stimulus: timeout_lim=20, halt_in never asserted;
   - response: done after 20 RUN cycles; cycle_count=20; timed_out=1.
   - Variant: halt on the same cycle gives timed_out=0.
5. Saturation:
   - stimulus: CNT_W=4, 20 instructions;
   - response: instr_count holds at 15; sat=1; sat clears at the next LOAD.
6. Restart and out-of-range select:
   - stimulus: start mid-RUN with prog_sel=3, NUM_PROGS=3;
   - response: LOAD with entry 0; counters cleared; run resumes.
